// File: rtl/imem_block_responder_if.sv
// rtl/imem_block_responder_if.sv - I-cache miss bus between the cache controller and the instruction memory
`ifndef IMEM_BLOCK_ADDR_SIZE
`define IMEM_BLOCK_ADDR_SIZE 9
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 128
`endif

interface imem_block_responder_if #(
   parameter int ADDR_W  = `IMEM_BLOCK_ADDR_SIZE,
   parameter int BLOCK_W = `IBLOCK_SIZE_BITS
);
   logic               memRen;
   logic [ADDR_W-1:0]  BlockAddr;
   logic               memReadReady;
   logic [BLOCK_W-1:0] memDout;

   modport master (output memRen, BlockAddr, input memReadReady, memDout);
   modport slave  (input memRen, BlockAddr, output memReadReady, memDout);
endinterface

// File: rtl/imem_block_responder.sv
// rtl/imem_block_responder.sv - instruction-memory block responder with programmable read latency
// Optional macro IMEM_BOUNDS_CHECK_EN adds memErr for out-of-range reads and loader writes.
`ifndef IMEM_BLOCK_ADDR_SIZE
`define IMEM_BLOCK_ADDR_SIZE 9
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 128
`endif

module imem_block_responder #(
   parameter int ADDR_W  = `IMEM_BLOCK_ADDR_SIZE,
   parameter int BLOCK_W = `IBLOCK_SIZE_BITS,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic                clock,
   input  logic                reset,
   imem_block_responder_if.slave bus,
   input  logic                loadWen,
   input  logic [ADDR_W-1:0]   loadAddr,
   input  logic [BLOCK_W-1:0]  loadDin
`ifdef IMEM_BOUNDS_CHECK_EN
   ,
   output logic                memErr
`endif
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt;
   logic [ADDR_W-1:0]  addr_q;
   logic [BLOCK_W-1:0] dout_q;
   logic [BLOCK_W-1:0] rd_data;
   logic               accept, dec, capture, ready;

   logic [BLOCK_W-1:0] mem [DEPTH];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.memRen) state_nxt = BUSY;
         BUSY:    if (!bus.memRen)   state_nxt = IDLE;
                  else if (cnt == '0) state_nxt = READY;
         READY:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept  = 1'b0;
      dec     = 1'b0;
      capture = 1'b0;
      ready   = 1'b0;
      case (state)
         IDLE:    accept = bus.memRen;
         BUSY:    if (bus.memRen) begin
                     if (cnt != '0) dec = 1'b1;
                     else           capture = 1'b1;
                  end
         READY:   ready = 1'b1;
         default: ;
      endcase
   end

   // Storage is deliberately unreset so loaded contents survive a controller reset.
   always_ff @(posedge clock) begin
      if (loadWen && in_range(loadAddr))
         mem[loadAddr[IDX_W-1:0]] <= loadDin;
   end

   assign rd_data = in_range(addr_q) ? mem[addr_q[IDX_W-1:0]] : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         cnt    <= '0;
         dout_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= bus.BlockAddr;
            cnt    <= 4'(LATENCY - 1);
         end else if (dec) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) dout_q <= rd_data;
      end
   end

`ifdef IMEM_BOUNDS_CHECK_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) memErr <= 1'b0;
      else        memErr <= (capture && !in_range(addr_q)) || (loadWen && !in_range(loadAddr));
   end
`endif

   assign bus.memReadReady = ready;
   assign bus.memDout      = dout_q;
endmodule

// File: doc/imem_block_responder.md
Name: imem_block_responder

Overview:
- Instruction-memory responder: the memory end of the I-cache miss protocol (memRen / BlockAddr / memReadReady / memDout).
- Accepts a block read request, waits a programmable latency, then returns one full I-cache block with a single-cycle ready pulse.
- Holds a block-wide storage array, initialised through a bench/loader write port.
- Sits between the I-cache controller and the top-level testbench, replacing the ideal memory model.

Parameters:
- ADDR_W, `IMEM_BLOCK_ADDR_SIZE: block address width.
- BLOCK_W, `IBLOCK_SIZE_BITS: block data width.
- DEPTH, 256: number of blocks stored; must be ≤ 2^ADDR_W.
- LATENCY, 4: cycles from request acceptance to ready; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memRen  in  1  read request, held high by the controller until ready is seen.
- BlockAddr  in  ADDR_W  requested block address.
- memReadReady  out  1  one-cycle pulse: memDout is valid.
- memDout  out  BLOCK_W  returned block, registered.
- loadWen  in  1  loader write strobe.
- loadAddr  in  ADDR_W  loader block address.
- loadDin  in  BLOCK_W  loader block data.

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0, memReadReady=0, memDout=0, latched address=0. The storage array is not reset and keeps its contents.
- FSM states:
  - IDLE: at a rising edge with memRen=1, latch BlockAddr, load counter=LATENCY-1, go to BUSY. With memRen=0, stay in IDLE.
  - BUSY: if memRen=0 at an edge, abort to IDLE with no ready and memDout unchanged. Else if counter≠0, decrement. Else (counter=0), register memDout = array[latched addr], set memReadReady=1, go to READY.
  - READY: one cycle long. memReadReady drops at the next edge; state returns to IDLE. memRen is ignored in this cycle.
- Latency: if the request is accepted at edge E0, memReadReady is high during the cycle after edge E0+LATENCY.
  - LATENCY=1 → ready in the cycle right after the acceptance edge plus one.
- memDout hold: memDout stays stable from the ready edge until the next ready edge or reset. This covers the controller's cache-write cycle that follows ready.
- BlockAddr changes while BUSY are ignored; the latched address is used.
- Back-to-back: a new request is accepted from IDLE on the cycle after READY. Sustained throughput is one block per LATENCY+2 cycles.
- Loader port: when loadWen=1 at an edge, array[loadAddr] ← loadDin. This works in any state.
  - A write at the same edge as the ready capture to the same address: memDout gets the old data.
  - An earlier write to that address is visible in the returned block.
- Out-of-range addresses (≥DEPTH) without the optional feature: read data is 0, writes are dropped.
- memReadReady never asserts without a preceding accepted request.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output port memErr (1 bit, reset 0).
  - A read whose latched address ≥ DEPTH still completes with normal timing and returns memDout=0.
  - memErr pulses high in the same cycle as memReadReady.
  - An out-of-range loader write pulses memErr for one cycle after the write edge.
- Undefined: no memErr port; out-of-range behaviour is as in Behaviour (silent zero, dropped writes).

Test Plan:
- Reset then idle 10 cycles with memRen=0 → memReadReady=0, memDout=0 throughout.
- Load array[5]=pattern A5A5…; memRen=1, BlockAddr=5 held (LATENCY=4) → ready high exactly in cycle 5 after acceptance, for one cycle; memDout=A5A5…, still stable 3 cycles later.
- Accept request for addr 5, change BlockAddr to 9 two cycles later → returned data is array[5].
- Drop memRen after 2 BUSY cycles → no ready pulse, FSM in IDLE; a new request for addr 7 completes normally with array[7].
- Two back-to-back requests (addr 1, then addr 2 issued the cycle after READY) → two ready pulses 6 cycles apart, correct data each.
- Assert reset mid-BUSY → memReadReady=0 and memDout=0 immediately, no later ready. With IMEM_BOUNDS_CHECK_EN, a read of addr DEPTH → memDout=0 and memErr pulses with ready.
